br_resolve: RTL and testbench

//  Execute-stage branch resolution unit; the producer of the predictor's update and redirect signals.

---
 rtl/rv_bp_pkg.sv | 26 ++
 rtl/br_resolve_if.sv | 34 +++
 rtl/bp_fifo.sv | 61 ++++++
 rtl/br_resolve.sv | 144 ++++++++++++++
 tb/tb_br_resolve.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_bp_pkg.sv
// Shared types for the execute-stage branch resolution slice: PC type,
// prediction queue entry, control-flow opcodes, FSM state, next-PC helper.
package rv_bp_pkg;

  typedef logic [47:0] pc_t;

  typedef struct packed {
    pc_t pc;
    pc_t pred_pc;
  } bp_entry_t;

  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

  // Architecturally correct successor of a completing instruction.
  function automatic pc_t next_pc(pc_t pc, logic is_ctrl, logic taken, pc_t target);
    return (is_ctrl && taken) ? target : pc + pc_t'(4);
  endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Fetch-side prediction push, EX-side resolve, and predictor/pipeline
// redirect signals of the branch resolution unit.
interface br_resolve_if;
  import rv_bp_pkg::*;

  logic fe_valid;
  pc_t  fe_pc;
  pc_t  fe_pred_pc;
  logic fe_ready;

  logic ex_valid;
  pc_t  ex_pc;
  logic ex_is_ctrl;
  logic ex_taken;
  pc_t  ex_target;

  logic mispred_ex;
  pc_t  correct_pc_ex;
  pc_t  index_pc_ex;
  logic flush;

  // Pipeline side: drives fetched predictions and EX completions.
  modport master (
    output fe_valid, fe_pc, fe_pred_pc, ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target,
    input  fe_ready, mispred_ex, correct_pc_ex, index_pc_ex, flush
  );

  // Resolution unit side.
  modport slave (
    input  fe_valid, fe_pc, fe_pred_pc, ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target,
    output fe_ready, mispred_ex, correct_pc_ex, index_pc_ex, flush
  );

endinterface

// File: rtl/bp_fifo.sv
// In-order synchronous FIFO for in-flight predictions. Callers only push
// when not full and only pop when not empty; clear wins over push/pop.
module bp_fifo
  import rv_bp_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = bp_entry_t
) (
  input  logic clk,
  input  logic n_reset,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  T     din,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Entry storage write.
  // NOTE: storage is deliberately not reset; pointers and count alone decide
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/br_resolve.sv
// Execute-stage branch resolution: queues fetch-time predictions, checks
// each against the true next PC at EX, redirects the predictor and holds a
// timed flush on a mispredict.
module br_resolve
  import rv_bp_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  br_resolve_if.slave      bus,
  output logic             desync_err,
  output logic [CNT_W-1:0] stat_ctrl_cnt,
  output logic [CNT_W-1:0] stat_mispred_cnt
);

  localparam int TIMER_W = $clog2(FLUSH_LEN + 1);

  br_state_t        state;
  logic [TIMER_W-1:0] flush_timer;
  logic             mispred_q;
  logic             flush_q;
  pc_t              correct_q;
  pc_t              index_q;

  bp_entry_t fe_entry;
  bp_entry_t head;
  logic      full;
  logic      empty;
  logic      run;
  logic      fe_ready;
  logic      resolve;
  logic      desync;
  logic      mismatch;
  logic      push;
  logic      pop;
  pc_t       actual;

  assign run      = (state == ST_RUN);
  assign fe_ready = run && !full;
  assign resolve  = run && bus.ex_valid;
  assign desync   = resolve && (empty || (bus.ex_pc != head.pc));
  assign actual   = next_pc(bus.ex_pc, bus.ex_is_ctrl, bus.ex_taken, bus.ex_target);
  assign mismatch = resolve && !desync && (actual != head.pred_pc);
  assign pop      = resolve && !empty;
  // Fetches arriving alongside a mispredict are wrong-path and dropped.
  assign push     = bus.fe_valid && fe_ready && !mismatch;
  assign fe_entry = '{pc: bus.fe_pc, pred_pc: bus.fe_pred_pc};

  bp_fifo #(.DEPTH(DEPTH), .T(bp_entry_t)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .pop     (pop),
    .clear   (mismatch),
    .din     (fe_entry),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // RUN/FLUSH control with registered redirect outputs and flush timer.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_RUN;
      flush_timer <= '0;
      mispred_q   <= 1'b0;
      flush_q     <= 1'b0;
      correct_q   <= '0;
      index_q     <= '0;
    end else begin
      mispred_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (mismatch) begin
            state       <= ST_FLUSH;
            flush_timer <= TIMER_W'(FLUSH_LEN - 1);
            mispred_q   <= 1'b1;
            flush_q     <= 1'b1;
            correct_q   <= actual;
            index_q     <= bus.ex_pc;
          end
        end
        ST_FLUSH: begin
          if (flush_timer == '0) begin
            state   <= ST_RUN;
            flush_q <= 1'b0;
          end else begin
            flush_timer <= flush_timer - 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Sticky queue/EX ordering error flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)    desync_err <= 1'b0;
    else if (desync) desync_err <= 1'b1;
  end

  // Saturating statistics, updated only on well-ordered resolves.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stat_ctrl_cnt    <= '0;
      stat_mispred_cnt <= '0;
    end else if (resolve && !desync) begin
      if (bus.ex_is_ctrl && (stat_ctrl_cnt != '1)) stat_ctrl_cnt <= stat_ctrl_cnt + 1'b1;
      if (mismatch && (stat_mispred_cnt != '1))    stat_mispred_cnt <= stat_mispred_cnt + 1'b1;
    end
  end

  assign bus.fe_ready      = fe_ready;
  assign bus.mispred_ex    = mispred_q;
  assign bus.flush         = flush_q;
  assign bus.correct_pc_ex = correct_q;
  assign bus.index_pc_ex   = index_q;

  a_mispred_single: assert property (@(posedge clk) disable iff (!n_reset) mispred_q |=> !mispred_q);
  a_ready_not_full: assert property (@(posedge clk) disable iff (!n_reset) !(fe_ready && full));

`ifndef SYNTHESIS
  int flush_run;

  // Length of the current flush pulse, for the pulse-width check below.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)    flush_run <= 0;
    else if (flush_q) flush_run <= flush_run + 1;
    else             flush_run <= 0;
  end

  // Every flush pulse starts with a mispredict and lasts exactly FLUSH_LEN.
  always @(posedge clk) begin
    if (n_reset) begin
      if (flush_q && flush_run == 0) a_flush_start: assert (mispred_q);
      if (!flush_q && flush_run != 0) a_flush_len: assert (flush_run == FLUSH_LEN);
    end
  end
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_br_resolve;
  import rv_bp_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             n_reset;
  logic             desync_err;
  logic [CNT_W-1:0] stat_ctrl_cnt;
  logic [CNT_W-1:0] stat_mispred_cnt;

  int checks = 0;
  int errors = 0;

  br_resolve_if bus ();

  br_resolve #(.DEPTH(8), .FLUSH_LEN(2), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .bus              (bus),
    .desync_err       (desync_err),
    .stat_ctrl_cnt    (stat_ctrl_cnt),
    .stat_mispred_cnt (stat_mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fe_valid   = 1'b0;
    bus.fe_pc      = '0;
    bus.fe_pred_pc = '0;
    bus.ex_valid   = 1'b0;
    bus.ex_pc      = '0;
    bus.ex_is_ctrl = 1'b0;
    bus.ex_taken   = 1'b0;
    bus.ex_target  = '0;
  endtask

  task automatic set_fe(input pc_t pc, input pc_t pred);
    bus.fe_valid   = 1'b1;
    bus.fe_pc      = pc;
    bus.fe_pred_pc = pred;
  endtask

  task automatic set_ex(input pc_t pc, input logic is_ctrl, input logic taken, input pc_t target);
    bus.ex_valid   = 1'b1;
    bus.ex_pc      = pc;
    bus.ex_is_ctrl = is_ctrl;
    bus.ex_taken   = taken;
    bus.ex_target  = target;
  endtask

  initial begin
    n_reset = 1'b0;
    idle_inputs();
    #3;
    check("rst_fe_ready", bus.fe_ready, 1);
    check("rst_mispred", bus.mispred_ex, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_desync", desync_err, 0);
    check("rst_ctrl_cnt", stat_ctrl_cnt, 0);
    check("rst_correct", bus.correct_pc_ex, 0);
    cyc();
    n_reset = 1'b1;
    cyc();

    // 1: correct non-control instruction
    set_fe(48'h1000, 48'h1004);
    cyc();
    idle_inputs();
    set_ex(48'h1000, 1'b0, 1'b0, 48'h0);
    cyc();
    idle_inputs();
    check("t1_mispred", bus.mispred_ex, 0);
    check("t1_flush", bus.flush, 0);
    check("t1_ctrl_cnt", stat_ctrl_cnt, 0);
    check("t1_desync", desync_err, 0);

    // 2: taken branch predicted fall-through; a same-cycle fetch is wrong-path
    set_fe(48'h2000, 48'h2004);
    cyc();
    idle_inputs();
    set_ex(48'h2000, 1'b1, 1'b1, 48'h3000);
    set_fe(48'h2004, 48'h2008);
    cyc();
    idle_inputs();
    check("t2_mispred", bus.mispred_ex, 1);
    check("t2_correct", bus.correct_pc_ex, 48'h3000);
    check("t2_index", bus.index_pc_ex, 48'h2000);
    check("t2_flush1", bus.flush, 1);
    check("t2_ready_flush1", bus.fe_ready, 0);
    check("t2_mispred_cnt", stat_mispred_cnt, 1);
    check("t2_ctrl_cnt", stat_ctrl_cnt, 1);
    // inputs during flush must be ignored
    set_fe(48'h7000, 48'h7004);
    set_ex(48'h7000, 1'b1, 1'b1, 48'h7100);
    cyc();
    idle_inputs();
    check("t2_mispred_once", bus.mispred_ex, 0);
    check("t2_flush2", bus.flush, 1);
    check("t2_ready_flush2", bus.fe_ready, 0);
    check("t2_correct_hold", bus.correct_pc_ex, 48'h3000);
    check("t2_ctrl_cnt_flush", stat_ctrl_cnt, 1);
    cyc();
    check("t2_flush_done", bus.flush, 0);
    check("t2_ready_back", bus.fe_ready, 1);
    check("t2_desync_flush", desync_err, 0);

    // 3: fill the queue; a stray entry would make it full one push early
    for (int i = 0; i < 8; i++) begin
      set_fe(48'h4000 + pc_t'(4 * i), 48'h4004 + pc_t'(4 * i));
      cyc();
      if (i == 6) check("t3_ready_at7", bus.fe_ready, 1);
    end
    idle_inputs();
    check("t3_ready_full", bus.fe_ready, 0);
    set_fe(48'h9000, 48'h9004);
    set_ex(48'h4000, 1'b0, 1'b0, 48'h0);
    cyc();
    idle_inputs();
    check("t3_ready_after_pop", bus.fe_ready, 1);
    check("t3_mispred", bus.mispred_ex, 0);

    // 4: desync (head pc is 0x4004); pop still happens, no counter update
    set_ex(48'h5000, 1'b1, 1'b1, 48'h6000);
    cyc();
    idle_inputs();
    check("t4_desync", desync_err, 1);
    check("t4_mispred", bus.mispred_ex, 0);
    check("t4_flush", bus.flush, 0);
    check("t4_ctrl_cnt", stat_ctrl_cnt, 1);
    cyc();
    check("t4_desync_sticky", desync_err, 1);
    // drain the remaining six entries with correctly predicted taken branches
    for (int i = 2; i < 8; i++) begin
      set_ex(48'h4000 + pc_t'(4 * i), 1'b1, 1'b1, 48'h4004 + pc_t'(4 * i));
      cyc();
      check("t4_drain_mispred", bus.mispred_ex, 0);
    end
    idle_inputs();
    check("t4_drain_ctrl_cnt", stat_ctrl_cnt, 7);
    check("t4_drain_mispred_cnt", stat_mispred_cnt, 1);

    // 5: next PC wraps modulo 2^48
    set_fe(48'hFFFF_FFFF_FFFC, 48'h0);
    cyc();
    idle_inputs();
    set_ex(48'hFFFF_FFFF_FFFC, 1'b0, 1'b0, 48'h0);
    cyc();
    idle_inputs();
    check("t5_wrap_mispred", bus.mispred_ex, 0);
    check("t5_wrap_flush", bus.flush, 0);

    // not-taken branch correctly predicted, then one predicted taken wrongly
    set_fe(48'h6000, 48'h6004);
    cyc();
    set_fe(48'h6100, 48'h8000);
    cyc();
    idle_inputs();
    set_ex(48'h6000, 1'b1, 1'b0, 48'h8000);
    cyc();
    check("t5_nt_ok", bus.mispred_ex, 0);
    check("t5_nt_ctrl_cnt", stat_ctrl_cnt, 8);
    set_ex(48'h6100, 1'b1, 1'b0, 48'h8000);
    cyc();
    idle_inputs();
    check("t5_nt_mispred", bus.mispred_ex, 1);
    check("t5_nt_correct", bus.correct_pc_ex, 48'h6104);
    check("t5_nt_index", bus.index_pc_ex, 48'h6100);
    check("t5_nt_mispred_cnt", stat_mispred_cnt, 2);
    check("t5_nt_ctrl_cnt2", stat_ctrl_cnt, 9);
    cyc();
    cyc();
    check("t5_flush_done", bus.flush, 0);

    // 6: reset during the first flush cycle
    set_fe(48'hA000, 48'hB000);
    cyc();
    idle_inputs();
    set_ex(48'hA000, 1'b0, 1'b0, 48'h0);
    cyc();
    idle_inputs();
    check("t6_flush1", bus.flush, 1);
    #2;
    n_reset = 1'b0;
    #1;
    check("t6_rst_flush", bus.flush, 0);
    check("t6_rst_ready", bus.fe_ready, 1);
    check("t6_rst_ctrl_cnt", stat_ctrl_cnt, 0);
    check("t6_rst_mispred_cnt", stat_mispred_cnt, 0);
    check("t6_rst_mispred", bus.mispred_ex, 0);
    check("t6_rst_desync", desync_err, 0);
    check("t6_rst_index", bus.index_pc_ex, 0);
    cyc();
    n_reset = 1'b1;
    cyc();

    // pop on an empty queue is a desync
    set_ex(48'hC000, 1'b1, 1'b1, 48'hD000);
    cyc();
    idle_inputs();
    check("t7_empty_desync", desync_err, 1);
    check("t7_empty_mispred", bus.mispred_ex, 0);
    check("t7_empty_ctrl_cnt", stat_ctrl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
